pc_sequencer: RTL and testbench

- Control block that sequences the PC register and the IF/ID and ID/EX pipeline registers.
- Generates next_pc, pc_stall and pc_flush for the PC register. Generates stall/flush for the front-end pipeline registers.
- Arbitrates among PC sources by priority: trap, EX-stage branch, ID-stage jump, sequential (+4).
- Absorbs multi-cycle instruction-memory fetches by latching any redirect that arrives mid-fetch.

---
 rtl/pc_sequencer_if.sv | 46 ++++
 rtl/pc_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Front-end sequencing bundle between the pipeline (master) and pc_sequencer (slave).
// Define PC_SEQUENCER_PERF_EN to add the performance counter outputs.
interface pc_sequencer_if #(
    parameter int ADDRESS_WIDTH = 12
);
    logic [ADDRESS_WIDTH-1:0] pc_current;
    logic                     imem_ready;
    logic                     load_use_hazard;
    logic                     jump_valid;
    logic [ADDRESS_WIDTH-1:0] jump_target;
    logic                     branch_taken;
    logic [ADDRESS_WIDTH-1:0] branch_target;
    logic                     trap_req;
    logic                     halt_req;
    logic                     resume;

    logic [ADDRESS_WIDTH-1:0] next_pc;
    logic                     pc_stall;
    logic                     pc_flush;
    logic                     if_id_stall;
    logic                     if_id_flush;
    logic                     id_ex_flush;
    logic [1:0]               seq_state;
`ifdef PC_SEQUENCER_PERF_EN
    logic [31:0]              perf_stall_cnt;
    logic [31:0]              perf_redirect_cnt;
`endif

    modport master (
`ifdef PC_SEQUENCER_PERF_EN
        input  perf_stall_cnt, perf_redirect_cnt,
`endif
        output pc_current, imem_ready, load_use_hazard, jump_valid, jump_target,
               branch_taken, branch_target, trap_req, halt_req, resume,
        input  next_pc, pc_stall, pc_flush, if_id_stall, if_id_flush, id_ex_flush, seq_state
    );

    modport slave (
`ifdef PC_SEQUENCER_PERF_EN
        output perf_stall_cnt, perf_redirect_cnt,
`endif
        input  pc_current, imem_ready, load_use_hazard, jump_valid, jump_target,
               branch_taken, branch_target, trap_req, halt_req, resume,
        output next_pc, pc_stall, pc_flush, if_id_stall, if_id_flush, id_ex_flush, seq_state
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC / IF-ID / ID-EX sequencer: trap > branch > jump > sequential, with redirects latched across slow fetches.
// Outputs are combinational from state and inputs; PC_SEQUENCER_PERF_EN adds saturating stall/redirect counters.
module pc_sequencer #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int DRAIN_CYCLES  = 3,
    parameter int PC_STEP       = 4
) (
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    typedef logic [ADDRESS_WIDTH-1:0] addr_t;
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FETCH_WAIT = 2'd1,
        TRAP_DRAIN = 2'd2,
        HALTED     = 2'd3
    } state_t;

    localparam addr_t      STEP       = addr_t'(PC_STEP);
    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

    state_t     state, state_nxt;
    logic       pend_valid, pend_valid_nxt;
    addr_t      pend_target, pend_target_nxt;
    logic [3:0] drain_cnt, drain_nxt;

    addr_t next_pc;
    logic  pc_stall, pc_flush, if_id_stall, if_id_flush, id_ex_flush;
    logic  redirect;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= RUN;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            drain_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            pend_valid  <= pend_valid_nxt;
            pend_target <= pend_target_nxt;
            drain_cnt   <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pend_valid_nxt  = pend_valid;
        pend_target_nxt = pend_target;
        drain_nxt       = drain_cnt;
        next_pc         = bus.pc_current + STEP;
        pc_stall        = 1'b0;
        pc_flush        = 1'b0;
        if_id_stall     = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        redirect        = 1'b0;

        // A trap wins in every state except TRAP_DRAIN, where it only restarts the drain.
        if (bus.trap_req && state != TRAP_DRAIN) begin
            pc_flush       = 1'b1;
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
            pend_valid_nxt = 1'b0;
            drain_nxt      = DRAIN_INIT;
            state_nxt      = TRAP_DRAIN;
        end else begin
            case (state)
                RUN: begin
                    if (bus.halt_req) begin
                        pc_stall    = 1'b1;
                        if_id_flush = 1'b1;
                        state_nxt   = HALTED;
                    end else if (bus.branch_taken || bus.jump_valid) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = bus.branch_taken;
                        if (bus.imem_ready) begin
                            next_pc  = bus.branch_taken ? bus.branch_target : bus.jump_target;
                            redirect = 1'b1;
                        end else begin
                            pc_stall        = 1'b1;
                            pend_valid_nxt  = 1'b1;
                            pend_target_nxt = bus.branch_taken ? bus.branch_target : bus.jump_target;
                            state_nxt       = FETCH_WAIT;
                        end
                    end else if (bus.load_use_hazard) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (!bus.imem_ready) begin
                        pc_stall    = 1'b1;
                        if_id_flush = 1'b1;
                        state_nxt   = FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (bus.branch_taken) begin
                        id_ex_flush     = 1'b1;
                        pend_valid_nxt  = 1'b1;
                        pend_target_nxt = bus.branch_target;
                    end else if (bus.jump_valid && !pend_valid) begin
                        pend_valid_nxt  = 1'b1;
                        pend_target_nxt = bus.jump_target;
                    end
                    if (!bus.imem_ready) begin
                        pc_stall    = 1'b1;
                        if_id_flush = 1'b1;
                    end else begin
                        // A redirect arriving on the completion cycle is honoured immediately.
                        if (pend_valid_nxt) begin
                            next_pc  = pend_target_nxt;
                            redirect = 1'b1;
                        end
                        pend_valid_nxt = 1'b0;
                        state_nxt      = RUN;
                    end
                end
                TRAP_DRAIN: begin
                    pc_stall    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (bus.trap_req) begin
                        drain_nxt = DRAIN_INIT;
                    end else if (drain_cnt <= 4'd1) begin
                        drain_nxt = '0;
                        state_nxt = RUN;
                    end else begin
                        drain_nxt = drain_cnt - 4'd1;
                    end
                end
                default: begin
                    pc_stall    = 1'b1;
                    if_id_flush = 1'b1;
                    if (bus.resume && !bus.halt_req) begin
                        state_nxt = RUN;
                    end
                end
            endcase
        end

        if (!reset) begin
            next_pc     = bus.pc_current;
            pc_stall    = 1'b1;
            pc_flush    = 1'b0;
            if_id_stall = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            redirect    = 1'b0;
        end
    end

    assign bus.next_pc     = next_pc;
    assign bus.pc_stall    = pc_stall;
    assign bus.pc_flush    = pc_flush;
    assign bus.if_id_stall = if_id_stall;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_flush = id_ex_flush;
    assign bus.seq_state   = state;

`ifdef PC_SEQUENCER_PERF_EN
    logic [31:0] stall_cnt, redirect_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (pc_stall && stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (redirect && !pc_stall && redirect_cnt != 32'hFFFF_FFFF) begin
                redirect_cnt <= redirect_cnt + 32'd1;
            end
        end
    end

    assign bus.perf_stall_cnt    = stall_cnt;
    assign bus.perf_redirect_cnt = redirect_cnt;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver pushes model expectations, negedge monitor pops and compares.
module tb_pc_sequencer;
    localparam int AW    = 12;
    localparam int DRAIN = 3;

    localparam int M_RUN   = 0;
    localparam int M_WAIT  = 1;
    localparam int M_DRAIN = 2;
    localparam int M_HALT  = 3;

    typedef struct packed {
        logic          rst;
        logic [AW-1:0] pc;
        logic          imem;
        logic          lu;
        logic          jv;
        logic [AW-1:0] jt;
        logic          br;
        logic [AW-1:0] bt;
        logic          trap;
        logic          halt;
        logic          resume;
    } stim_t;

    typedef struct packed {
        logic [AW-1:0] next_pc;
        logic          pc_stall;
        logic          pc_flush;
        logic          if_id_stall;
        logic          if_id_flush;
        logic          id_ex_flush;
        logic [1:0]    seq_state;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDRESS_WIDTH(AW)) bus ();

    pc_sequencer #(
        .ADDRESS_WIDTH(AW),
        .DRAIN_CYCLES (DRAIN),
        .PC_STEP      (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // Reference model: mode, list of pending redirects (at most one), remaining drain cycles.
    int            m_mode, n_mode;
    logic [AW-1:0] m_pend[$];
    logic [AW-1:0] n_pend[$];
    int            m_drain, n_drain;

    task automatic take_trap(inout exp_t e);
        e.pc_stall    = 1'b0;
        e.pc_flush    = 1'b1;
        e.if_id_flush = 1'b1;
        e.id_ex_flush = 1'b1;
        n_mode  = M_DRAIN;
        n_drain = DRAIN;
        n_pend.delete();
    endtask

    task automatic model(input stim_t s, output exp_t e);
        logic [AW-1:0] tgt;
        e = '0;
        e.next_pc   = s.pc + 12'd4;
        e.seq_state = 2'(m_mode);
        n_mode  = m_mode;
        n_pend  = m_pend;
        n_drain = m_drain;
        if (!s.rst) begin
            e.next_pc     = s.pc;
            e.pc_stall    = 1'b1;
            e.if_id_flush = 1'b1;
            e.id_ex_flush = 1'b1;
            n_mode  = M_RUN;
            n_drain = 0;
            n_pend.delete();
            return;
        end
        if (m_mode == M_DRAIN) begin
            e.pc_stall = 1'b1; e.if_id_flush = 1'b1; e.id_ex_flush = 1'b1;
            if (s.trap) n_drain = DRAIN;
            else begin
                n_drain = m_drain - 1;
                if (n_drain <= 0) n_mode = M_RUN;
            end
        end else if (s.trap) begin
            take_trap(e);
        end else if (m_mode == M_HALT) begin
            e.pc_stall = 1'b1; e.if_id_flush = 1'b1;
            if (s.resume && !s.halt) n_mode = M_RUN;
        end else if (m_mode == M_WAIT) begin
            if (s.br) begin
                e.id_ex_flush = 1'b1;
                n_pend = '{s.bt};
            end else if (s.jv && m_pend.size() == 0) begin
                n_pend = '{s.jt};
            end
            if (!s.imem) begin
                e.pc_stall = 1'b1; e.if_id_flush = 1'b1;
            end else begin
                if (n_pend.size() != 0) e.next_pc = n_pend[0];
                n_pend.delete();
                n_mode = M_RUN;
            end
        end else if (s.halt) begin
            e.pc_stall = 1'b1; e.if_id_flush = 1'b1;
            n_mode = M_HALT;
        end else if (s.br || s.jv) begin
            tgt = s.br ? s.bt : s.jt;
            e.if_id_flush = 1'b1;
            e.id_ex_flush = s.br;
            if (s.imem) e.next_pc = tgt;
            else begin
                e.pc_stall = 1'b1;
                n_pend = '{tgt};
                n_mode = M_WAIT;
            end
        end else if (s.lu) begin
            e.pc_stall = 1'b1; e.if_id_stall = 1'b1; e.id_ex_flush = 1'b1;
        end else if (!s.imem) begin
            e.pc_stall = 1'b1; e.if_id_flush = 1'b1;
            n_mode = M_WAIT;
        end
    endtask

    task automatic apply(input stim_t s);
        reset               = s.rst;
        bus.pc_current      = s.pc;
        bus.imem_ready      = s.imem;
        bus.load_use_hazard = s.lu;
        bus.jump_valid      = s.jv;
        bus.jump_target     = s.jt;
        bus.branch_taken    = s.br;
        bus.branch_target   = s.bt;
        bus.trap_req        = s.trap;
        bus.halt_req        = s.halt;
        bus.resume          = s.resume;
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        apply(s);
        model(s, e);
        exp_q.push_back(e);
        @(posedge clk);
        m_mode  = n_mode;
        m_pend  = n_pend;
        m_drain = n_drain;
        #1;
    endtask

    function automatic stim_t base(input logic [AW-1:0] pc, input logic imem);
        stim_t s;
        s      = '0;
        s.rst  = 1'b1;
        s.pc   = pc;
        s.imem = imem;
        return s;
    endfunction

    task automatic cmp(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                cmp("next_pc",     bus.next_pc,            e.next_pc);
                cmp("pc_stall",    12'(bus.pc_stall),      12'(e.pc_stall));
                cmp("pc_flush",    12'(bus.pc_flush),      12'(e.pc_flush));
                cmp("if_id_stall", 12'(bus.if_id_stall),   12'(e.if_id_stall));
                cmp("if_id_flush", 12'(bus.if_id_flush),   12'(e.if_id_flush));
                cmp("id_ex_flush", 12'(bus.id_ex_flush),   12'(e.id_ex_flush));
                cmp("seq_state",   12'(bus.seq_state),     12'(e.seq_state));
            end
        end
    end

    initial begin
        stim_t s;
        logic [AW-1:0] pc;
        int wait_cnt;

        // First reset cycle establishes a known state; nothing is checked until it has been sampled.
        s = base(12'h000, 1'b1);
        s.rst = 1'b0;
        apply(s);
        @(posedge clk);
        #1;
        m_mode = M_RUN; m_drain = 0; m_pend.delete();

        // Reset held, then plain sequential fetch from 0.
        s = base(12'h000, 1'b1); s.rst = 1'b0; step(s);
        step(base(12'h000, 1'b1));

        // Branch outranks a simultaneous jump.
        s = base(12'h004, 1'b1);
        s.br = 1'b1; s.bt = 12'h120; s.jv = 1'b1; s.jt = 12'h200;
        step(s);

        // Slow fetch with a branch latched mid-fetch.
        step(base(12'h120, 1'b0));
        s = base(12'h120, 1'b0); s.br = 1'b1; s.bt = 12'h080; step(s);
        step(base(12'h120, 1'b0));
        step(base(12'h120, 1'b1));

        // Load-use stall then sequential advance.
        s = base(12'h080, 1'b1); s.lu = 1'b1; step(s);
        step(base(12'h080, 1'b1));

        // Trap, drain with branches ignored, then back to RUN.
        s = base(12'h084, 1'b1); s.trap = 1'b1; step(s);
        for (int i = 0; i < DRAIN; i++) begin
            s = base(12'h000, 1'b1); s.br = 1'b1; s.bt = 12'h3C0; s.halt = 1'b1; step(s);
        end
        step(base(12'h000, 1'b1));

        // Halt, resume together with trap, halt+resume stays halted.
        s = base(12'h004, 1'b1); s.halt = 1'b1; step(s);
        s = base(12'h004, 1'b1); s.halt = 1'b1; s.resume = 1'b1; step(s);
        s = base(12'h004, 1'b1); s.resume = 1'b1; s.trap = 1'b1; step(s);
        for (int i = 0; i < DRAIN; i++) step(base(12'h000, 1'b0));

        // Jump in a slow fetch, later branch overwrites; PC wrap.
        s = base(12'h010, 1'b0); s.jv = 1'b1; s.jt = 12'h300; step(s);
        s = base(12'h010, 1'b0); s.jv = 1'b1; s.jt = 12'h340; step(s);
        s = base(12'h010, 1'b1); s.br = 1'b1; s.bt = 12'h500; step(s);
        step(base(12'hFFC, 1'b1));

        // Randomised traffic, including resets mid-fetch and mid-drain.
        pc = 12'h100;
        for (int i = 0; i < 3000; i++) begin
            s        = base(pc, ($urandom_range(2, 0) != 0));
            s.rst    = ($urandom_range(63, 0) != 0);
            s.lu     = ($urandom_range(5, 0) == 0);
            s.jv     = ($urandom_range(4, 0) == 0);
            s.jt     = AW'($urandom);
            s.br     = ($urandom_range(5, 0) == 0);
            s.bt     = AW'($urandom);
            s.trap   = ($urandom_range(31, 0) == 0);
            s.halt   = ($urandom_range(15, 0) == 0);
            s.resume = ($urandom_range(3, 0) == 0);
            step(s);
            pc = ($urandom_range(7, 0) == 0) ? AW'($urandom) : pc + 12'd4;
        end

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
